// File: rtl/ps2_debounce_if.sv
// ps2_debounce_if: bundle of the two raw PS/2 lines and their debounced copies.
//   btn_in_1  : raw channel 1 (PS/2 clock line), asynchronous to clk
//   btn_in_2  : raw channel 2 (PS/2 data line), asynchronous to clk
//   btn_out_1 : debounced channel 1, registered
//   btn_out_2 : debounced channel 2, registered
// master drives the raw lines and observes the outputs; slave is the debouncer.
interface ps2_debounce_if;
    logic btn_in_1;
    logic btn_in_2;
    logic btn_out_1;
    logic btn_out_2;

    modport master (
        output btn_in_1,
        output btn_in_2,
        input  btn_out_1,
        input  btn_out_2
    );

    modport slave (
        input  btn_in_1,
        input  btn_in_2,
        output btn_out_1,
        output btn_out_2
    );
endinterface

// File: rtl/ps2_debounce.sv
// ps2_debounce: two independent debounce channels for the PS/2 clock and data lines.
// Each channel is a 2-flop synchronizer, a saturating-free run-length counter and an
// output register. The output follows the synchronized input only after the input
// has differed from the output for STABLE_COUNT consecutive cycles.
// Ports:
//   clk : single clock, all state on rising edge
//   rst : asynchronous active-high reset, forces everything to the idle level
//   bus : slave side of ps2_debounce_if (btn_in_1/2 raw, btn_out_1/2 debounced)
module ps2_debounce #(
    parameter int unsigned STABLE_COUNT = 19,
    parameter logic        RESET_LEVEL  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    ps2_debounce_if.slave bus
);

    localparam int unsigned N_CH  = 2;
    localparam int unsigned CNT_W = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT + 1) : 1;
    // The counter reaching this value means the next edge completes the run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    if (STABLE_COUNT < 1 || STABLE_COUNT > 255) begin : g_bad_stable_count
        $error("ps2_debounce: STABLE_COUNT must be in 1..255");
    end

    logic [N_CH-1:0]            raw;
    logic [N_CH-1:0]            meta_q;
    logic [N_CH-1:0]            sync_q;
    logic [N_CH-1:0]            out_q;
    logic [N_CH-1:0]            out_d;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q;
    logic [N_CH-1:0][CNT_W-1:0] cnt_d;

    assign raw = {bus.btn_in_2, bus.btn_in_1};

    // Run-length qualification: any cycle where sync matches the output restarts the run.
    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (sync_q[ch] != out_q[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    out_d[ch] = sync_q[ch];
                    cnt_d[ch] = '0;
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

    // Synchronizer, counter and output registers for both channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= {N_CH{RESET_LEVEL}};
            sync_q <= {N_CH{RESET_LEVEL}};
            out_q  <= {N_CH{RESET_LEVEL}};
            cnt_q  <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.btn_out_1 = out_q[0];
    assign bus.btn_out_2 = out_q[1];

endmodule

// File: tb/tb_ps2_debounce.sv
// tb_ps2_debounce: table-driven pulse vectors plus hand-written reset and bounce
// sequences for ps2_debounce (STABLE_COUNT = 19). Edge k = k-th rising edge that
// samples the driven input; a change sampled first at edge s shows at edge s+20.
module tb_ps2_debounce;

    localparam int unsigned SC  = 19;
    localparam int unsigned WIN = 75;

    typedef struct {
        int w1;  // edges channel 1 is held low (0 = no pulse)
        int w2;
        int f1;  // edge where btn_out_1 falls (0 = never)
        int r1;  // edge where btn_out_1 returns high
        int f2;
        int r2;
    } vec_t;

    typedef struct {
        logic  e1;
        logic  e2;
        string tag;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];
    vec_t vecs[7];

    ps2_debounce_if bus_if ();

    ps2_debounce #(
        .STABLE_COUNT (SC),
        .RESET_LEVEL  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs for the next edge, queue the expected outputs, compare after the edge.
    task automatic step(input logic i1, input logic i2, input logic e1, input logic e2,
                        input string tag);
        exp_t x;
        bus_if.btn_in_1 = i1;
        bus_if.btn_in_2 = i2;
        sb_q.push_back('{e1: e1, e2: e2, tag: tag});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            x = sb_q.pop_front();
            chk({x.tag, "_out1"}, 32'(bus_if.btn_out_1), 32'(x.e1));
            chk({x.tag, "_out2"}, 32'(bus_if.btn_out_2), 32'(x.e2));
        end
    endtask

    function automatic logic exp_level(input int k, input int f, input int r);
        return (f != 0 && k >= f && k < r) ? 1'b0 : 1'b1;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        //        w1  w2  f1  r1  f2  r2
        vecs[0] = '{30,  0, 21, 51,  0,  0};  // ch1 steady low, ch2 idle
        vecs[1] = '{ 0, 10,  0,  0,  0,  0};  // 10-cycle glitch on ch2
        vecs[2] = '{18, 19,  0,  0, 21, 40};  // one short of / exactly STABLE_COUNT
        vecs[3] = '{40,  8, 21, 61,  0,  0};  // both fall, ch2 recovers after 8
        vecs[4] = '{19, 19, 21, 40, 21, 40};  // both at the boundary together
        vecs[5] = '{ 1,  1,  0,  0,  0,  0};  // single-cycle spikes
        vecs[6] = '{25, 21, 21, 46, 21, 42};  // independent release times

        // Reset with idle-high inputs.
        rst = 1'b1;
        bus_if.btn_in_1 = 1'b1;
        bus_if.btn_in_2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out1", 32'(bus_if.btn_out_1), 32'd1);
        chk("rst_out2", 32'(bus_if.btn_out_2), 32'd1);
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) step(1'b1, 1'b1, 1'b1, 1'b1, "idle");
        chk("idle_cnt", 32'(dut.cnt_q), 32'd0);

        // Pulse vectors.
        for (int v = 0; v < 7; v++) begin
            for (int k = 1; k <= WIN; k++) begin
                step(!(k <= vecs[v].w1), !(k <= vecs[v].w2),
                     exp_level(k, vecs[v].f1, vecs[v].r1),
                     exp_level(k, vecs[v].f2, vecs[v].r2),
                     $sformatf("vec%0d_k%0d", v, k));
            end
            chk($sformatf("vec%0d_cnt", v), 32'(dut.cnt_q), 32'd0);
        end

        // Bounce every 5 cycles for 50 cycles, then hold low: fall at edge 51+20.
        for (int k = 1; k <= 80; k++) begin
            step((k <= 50) ? logic'(((k - 1) / 5) % 2) : 1'b0, 1'b1,
                 (k >= 71) ? 1'b0 : 1'b1, 1'b1, $sformatf("bounce_k%0d", k));
        end
        for (int k = 1; k <= 25; k++) begin
            step(1'b1, 1'b1, (k >= 21) ? 1'b1 : 1'b0, 1'b1, $sformatf("bounce_rel_k%0d", k));
        end

        // Reset at count 12 of a pending fall, released with the input still low.
        for (int k = 1; k <= 14; k++) step(1'b0, 1'b1, 1'b1, 1'b1, $sformatf("pre_rst_k%0d", k));
        chk("pre_rst_cnt", 32'(dut.cnt_q[0]), 32'd12);
        rst = 1'b1;
        #1;
        chk("midrst_cnt", 32'(dut.cnt_q), 32'd0);
        chk("midrst_sync", 32'(dut.sync_q), 32'd3);
        chk("midrst_out1", 32'(bus_if.btn_out_1), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b1, (k >= 21) ? 1'b0 : 1'b1, 1'b1, $sformatf("post_rst_k%0d", k));
        end

        // Asynchronous reset must raise a low output before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out1", 32'(bus_if.btn_out_1), 32'd1);
        chk("async_rst_out2", 32'(bus_if.btn_out_2), 32'd1);
        @(posedge clk);
        #1;
        bus_if.btn_in_1 = 1'b1;
        rst = 1'b0;
        for (int k = 1; k <= 25; k++) step(1'b1, 1'b1, 1'b1, 1'b1, $sformatf("final_k%0d", k));

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_debounce.md
PS2_DEBOUNCE -- requirements
Module: ps2_debounce

Interface
REQ-001 SHALL provide parameter STABLE_COUNT, default 19, number of consecutive clk cycles a synchronized input must differ from its output before the output follows; legal range 1..255.
REQ-002 SHALL provide parameter RESET_LEVEL, default 1'b1, the reset/idle level of both channels (PS/2 lines idle high).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge (driven at 50 MHz in system use).
REQ-004 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port btn_in_1, input, 1 bit: raw asynchronous channel 1 (PS/2 clock line).
REQ-006 SHALL have port btn_in_2, input, 1 bit: raw asynchronous channel 2 (PS/2 data line).
REQ-007 SHALL have port btn_out_1, output, 1 bit: debounced channel 1, registered.
REQ-008 SHALL have port btn_out_2, output, 1 bit: debounced channel 2, registered.

Function
REQ-009 SHALL process the two channels with identical, fully independent logic (synchronizer, counter, output register per channel).
REQ-010 SHALL pass each raw input through a 2-flop synchronizer; only the second-stage value (sync) feeds the debounce logic.
REQ-011 SHALL hold a per-channel counter of width ceil(log2(STABLE_COUNT+1)) bits.
REQ-012 SHALL, each clock when sync equals the output register, clear the counter to 0.
REQ-013 SHALL, each clock when sync differs from the output, increment the counter; on the edge where the incremented value would equal STABLE_COUNT, load output <= sync and clear the counter.
REQ-014 SHALL therefore update the output exactly STABLE_COUNT+2 rising edges after the first edge that samples the new raw level, provided the raw level stays constant throughout.
REQ-015 SHALL discard any pulse or glitch whose synchronized width is shorter than STABLE_COUNT cycles: output unchanged, counter back to 0 when sync returns.
REQ-016 SHALL restart the count from 0 whenever sync returns to the output level mid-count (no accumulation across bounces).
REQ-017 SHALL never let the counter exceed STABLE_COUNT or wrap.
REQ-018 SHALL drive outputs directly from flops (no combinational path from inputs to outputs).
REQ-019 SHALL treat simultaneous transitions on both channels independently; each output updates at its own qualified time.

Reset
REQ-020 SHALL, while rst=1, asynchronously force both synchronizer stages, both outputs to RESET_LEVEL and both counters to 0.
REQ-021 SHALL, after rst deasserts, resume normal operation on the next rising clk edge; a reset mid-count discards the count.
REQ-022 SHALL, if the raw input is at the non-reset level when rst deasserts, switch the output after STABLE_COUNT+2 edges per REQ-014.

Verification
REQ-023 Reset with inputs high, release -> btn_out_1=btn_out_2=1, counters 0, outputs stay 1 for 100 cycles.
REQ-024 btn_in_1 1->0 held steady (STABLE_COUNT=19) -> btn_out_1 falls exactly 21 edges after the first sampling edge; btn_out_2 stays 1.
REQ-025 btn_in_2 low pulse of 10 cycles -> btn_out_2 stays 1; counter returns to 0.
REQ-026 btn_in_1 bounces 0/1 every 5 cycles for 50 cycles, then held 0 -> single clean 1->0 on btn_out_1, 21 edges after the final transition.
REQ-027 Both inputs fall at once, btn_in_2 rises again after 8 cycles -> btn_out_1 falls at edge 21, btn_out_2 stays 1.
REQ-028 rst asserted at count 12 of a pending change, released with input still low -> outputs 1 immediately during reset, then btn_out falls 21 edges after release.
